// File: rtl/ecg_sample_buffer.sv
// ECG sample buffer: collects a block of samples, reports the block average,
// then streams the stored samples out over a valid/ready handshake.
module ecg_sample_buffer #(
    parameter int  DATA_W     = 12,
    parameter int  DEPTH      = 16,
    localparam int LOG2_DEPTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            state,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  sample_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     avg_out,
    output logic                  avg_valid,
    output logic                  done,
    output logic                  overflow,
    output logic [LOG2_DEPTH:0]   count
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ACQUIRE = 2'b01;
    localparam logic [1:0] ST_PROCESS = 2'b10;
    localparam logic [1:0] ST_OUTPUT  = 2'b11;

    localparam int              ACC_W  = DATA_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] L_FULL = (LOG2_DEPTH+1)'(DEPTH);

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [1:0]            r_prev_state;
    logic [ACC_W-1:0]      r_acc;
    logic [LOG2_DEPTH-1:0] r_rd;

    logic                  w_entry;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_last;
    logic [LOG2_DEPTH-1:0] w_rd_nxt;

    assign w_entry  = (state != r_prev_state);
    assign w_full   = (count == L_FULL);
    assign w_wr     = (state == ST_ACQUIRE) && sample_valid && !w_full;
    assign w_rd_nxt = r_rd + 1'b1;
    assign w_last   = ({1'b0, r_rd} == (count - 1'b1));

    // Storage is not reset; only the write path touches it.
    always_ff @(posedge clk) begin
        if (!rst && w_wr)
            r_mem[count[LOG2_DEPTH-1:0]] <= sample_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_state <= ST_IDLE;
            r_acc        <= '0;
            r_rd         <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            avg_out      <= '0;
            avg_valid    <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_prev_state <= state;
            avg_valid    <= 1'b0;
            done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    count     <= '0;
                    r_acc     <= '0;
                    r_rd      <= '0;
                    overflow  <= 1'b0;
                    out_valid <= 1'b0;
                end
                ST_ACQUIRE: begin
                    out_valid <= 1'b0;
                    if (sample_valid) begin
                        if (!w_full) begin
                            count <= count + 1'b1;
                            r_acc <= r_acc + {{LOG2_DEPTH{1'b0}}, sample_in};
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                ST_PROCESS: begin
                    out_valid <= 1'b0;
                    // Divide by full depth: a short block averages in zeros.
                    if (w_entry) begin
                        avg_out   <= DATA_W'(r_acc >> LOG2_DEPTH);
                        avg_valid <= 1'b1;
                    end
                end
                default: begin
                    if (w_entry) begin
                        r_rd <= '0;
                        if (count != '0) begin
                            out_valid <= 1'b1;
                            out_data  <= r_mem[0];
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (out_valid && out_ready) begin
                        if (w_last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            r_rd     <= w_rd_nxt;
                            out_data <= r_mem[w_rd_nxt];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecg_sample_buffer.sv
// Directed bench for ecg_sample_buffer: acquire/average, overflow, stalled
// streaming, empty output and reset mid-stream.
module tb_ecg_sample_buffer;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        state;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              done;
    logic              overflow;
    logic [4:0]        count;

    int n_chk = 0;
    int n_err = 0;

    ecg_sample_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .state        (state),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .done         (done),
        .overflow     (overflow),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        sample_valid = 1'b1;
        sample_in    = d;
        tick();
        sample_valid = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_beats [4];
        logic [DATA_W-1:0] held;
        int idx;
        int avg_pulses;
        int done_seen;
        logic xfer;

        rst = 1'b1; state = 2'b00; sample_in = '0; sample_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_avg_out", avg_out, 0);
        rst = 1'b0;
        tick();

        // Block average of 0x010..0x01F
        state = 2'b01;
        for (int i = 0; i < 16; i++) push(DATA_W'(12'h010 + i));
        chk("acq16_count", count, 16);
        chk("acq16_ovf", overflow, 0);
        state = 2'b10;
        tick();
        chk("avg_valid_pulse", avg_valid, 1);
        chk("avg_out_ramp", avg_out, 12'h017);
        avg_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (avg_valid) avg_pulses++;
        end
        chk("avg_no_repulse", avg_pulses, 0);
        chk("avg_out_hold", avg_out, 12'h017);

        // Overflow with full-scale samples
        state = 2'b00;
        tick();
        chk("idle_clear_count", count, 0);
        state = 2'b01;
        for (int i = 0; i < 16; i++) push(12'hFFF);
        chk("full_no_ovf_yet", overflow, 0);
        push(12'hFFF);
        chk("ovf_set", overflow, 1);
        push(12'hFFF);
        chk("ovf_count", count, 16);
        state = 2'b10;
        tick();
        chk("avg_fullscale", avg_out, 12'hFFF);
        chk("ovf_sticky", overflow, 1);
        state = 2'b00;
        tick();
        chk("idle_clear_ovf", overflow, 0);
        chk("idle_clear_count2", count, 0);
        push(12'h555);
        chk("idle_ignores_valid", count, 0);

        // Short block, then stream with a stalling sink
        exp_beats[0] = 12'h100; exp_beats[1] = 12'h200;
        exp_beats[2] = 12'h300; exp_beats[3] = 12'h400;
        state = 2'b01;
        for (int i = 0; i < 4; i++) push(exp_beats[i]);
        chk("acq4_count", count, 4);
        state = 2'b10;
        tick();
        chk("avg_short_block", avg_out, 12'h0A0);
        state = 2'b11; out_ready = 1'b0;
        tick();
        chk("out_first_valid", out_valid, 1);
        chk("out_first_data", out_data, 12'h100);
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            out_ready = (c % 2 == 0);
            held = out_data;
            xfer = out_valid && out_ready;
            tick();
            if (xfer) begin
                chk("beat_data", held, exp_beats[idx]);
                idx++;
                chk("done_on_last", done, (idx == 4));
                if (idx < 4) chk("next_beat", out_data, exp_beats[idx]);
            end else begin
                chk("stall_stable", out_data, held);
                chk("stall_valid", out_valid, 1);
            end
        end
        chk("stream_complete", idx, 4);
        chk("valid_low_after_done", out_valid, 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("valid_stays_low", out_valid, 0);

        // Output with nothing stored
        state = 2'b00;
        tick();
        state = 2'b11; out_ready = 1'b1;
        tick();
        chk("empty_done", done, 1);
        chk("empty_no_valid", out_valid, 0);
        tick();
        chk("empty_done_once", done, 0);
        chk("empty_no_valid2", out_valid, 0);

        // Reset asserted mid-stream
        state = 2'b00;
        tick();
        state = 2'b01;
        for (int i = 0; i < 16; i++) push(DATA_W'(12'h020 + i));
        state = 2'b11; out_ready = 1'b1;
        tick();
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("midstream_no_done", done_seen, 0);
        chk("midstream_beat5", out_data, 12'h025);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_count", count, 0);
        chk("arst_avg_out", avg_out, 0);
        chk("arst_done", done, 0);
        state = 2'b00;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_rst_done", done, 0);
        tick();
        chk("post_rst_count", count, 0);
        chk("post_rst_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ecg_sample_buffer.md
ECG_SAMPLE_BUFFER -- requirements
Module: ecg_sample_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning ECG sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning buffer entries; power of two, 2..256; LOG2_DEPTH derived.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port state  input  2  phase code from the control sequencer: 00 IDLE, 01 ACQUIRE, 10 PROCESS, 11 OUTPUT.
REQ-006 SHALL have port sample_in  input  DATA_W  unsigned ECG sample.
REQ-007 SHALL have port sample_valid  input  1  sample_in qualifier.
REQ-008 SHALL have port out_data  output  DATA_W  streamed sample, registered.
REQ-009 SHALL have port out_valid  output  1  out_data qualifier, registered.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port avg_out  output  DATA_W  block average, registered.
REQ-012 SHALL have port avg_valid  output  1  one-cycle pulse, avg_out updated.
REQ-013 SHALL have port done  output  1  one-cycle pulse, final stream beat accepted.
REQ-014 SHALL have port overflow  output  1  sticky flag, sample dropped while full.
REQ-015 SHALL have port count  output  LOG2_DEPTH+1  stored sample count.

Function
REQ-016 SHALL register state into prev_state each cycle; entry to a phase = state != prev_state, evaluated on the rising edge.
REQ-017 IDLE: SHALL clear count, write pointer, read pointer, accumulator, overflow each cycle; out_valid low; avg_out and buffer contents held.
REQ-018 ACQUIRE: sample_valid with count<DEPTH SHALL write sample_in at index count, increment count, add sample_in to accumulator, all in the same edge.
REQ-019 ACQUIRE: sample_valid with count==DEPTH SHALL drop the sample, leave count/accumulator unchanged, set overflow on that edge.
REQ-020 Accumulator SHALL be DATA_W+LOG2_DEPTH bits wide and never wrap (max DEPTH*(2^DATA_W-1) fits).
REQ-021 sample_valid outside ACQUIRE SHALL be ignored.
REQ-022 PROCESS entry: on the edge after entry, avg_out SHALL load accumulator>>LOG2_DEPTH (missing samples count as zero) and avg_valid SHALL pulse for exactly one cycle; no further pulse while PROCESS held.
REQ-023 OUTPUT entry: read pointer SHALL reset to 0; out_valid SHALL assert on the edge after entry if count>0, with out_data = buffer[0].
REQ-024 Handshake: beat transfers on edge with out_valid&&out_ready; out_data SHALL stay stable while out_valid&&!out_ready; out_valid SHALL never drop without a transfer while OUTPUT held.
REQ-025 After a transfer the next beat (buffer[rd+1]) SHALL be presented on the same edge, giving one beat per cycle with out_ready held high.
REQ-026 Transfer of beat count-1 SHALL deassert out_valid and pulse done for one cycle on the same edge; OUTPUT held afterwards SHALL keep out_valid low.
REQ-027 OUTPUT entered with count==0 SHALL pulse done on the edge after entry and never assert out_valid.
REQ-028 Leaving OUTPUT mid-stream SHALL deassert out_valid on the next edge with no done pulse; remaining samples discarded.
REQ-029 Direct transitions (e.g. ACQUIRE->OUTPUT, OUTPUT->ACQUIRE) SHALL be legal; ACQUIRE re-entry without IDLE SHALL append to existing count.
REQ-030 overflow SHALL stay set until IDLE or rst.

Reset
REQ-031 rst high SHALL immediately force out_valid, avg_valid, done, overflow, count, avg_out, out_data, pointers, accumulator, prev_state=IDLE to 0; buffer RAM content need not reset.
REQ-032 rst asserted mid-stream SHALL abort without done pulse; after release, state present on the line is treated as newly entered.

Verification
REQ-033 ACQUIRE, 16 samples 0x010..0x01F valid back-to-back, then PROCESS -> count=16, avg_out=0x017, one avg_valid pulse.
REQ-034 ACQUIRE, 18 samples of 0xFFF -> count=16, overflow=1, PROCESS avg_out=0xFFF; IDLE clears overflow and count.
REQ-035 4 samples 0x100,0x200,0x300,0x400, OUTPUT, out_ready toggling 1,0,1,0... -> beats 0x100..0x400 in order, data stable while stalled, done pulse on 4th transfer.
REQ-036 OUTPUT with count=0 -> out_valid never high, done pulses once one edge after entry.
REQ-037 16 samples, OUTPUT, out_ready high, rst asserted after 5 beats -> all outputs 0 immediately, no done; after release with state=IDLE count stays 0.
